bus_responder: RTL and testbench

- Bus-side counterpart to the 65C02 core: decodes the CPU address bus (AD, DO, WE), returns read data on DI, and paces the CPU through RDY.
- Contains an internal synchronous RAM, mirrored over all addresses outside the I/O window.
- Bridges accesses inside the I/O window to a slow peripheral port using a req/ack handshake. Wait states are inserted and a timeout guards against dead peripherals.

---
 rtl/cpu_bus_pkg.sv | 22 ++
 rtl/bus_responder_io_port_fsm.sv | 94 +++++++++
 rtl/bus_responder.sv | 83 ++++++++
 tb/tb_bus_responder.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the 65C02 bus responder: I/O FSM state
// encoding, default I/O window placement and the open-bus read value.
package cpu_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } io_state_e;

    localparam logic [15:0] IO_BASE_DEF = 16'hFE00;
    localparam int          IO_AW_DEF   = 8;
    localparam logic [7:0]  OPEN_BUS    = 8'hFF;

    // The window is aligned, so only the bits above the window width matter.
    function automatic logic in_io_window(input logic [15:0] addr,
                                          input logic [15:0] base,
                                          input int          aw);
        return ((addr >> aw) == (base >> aw));
    endfunction

endpackage

// File: rtl/bus_responder_io_port_fsm.sv
// Slow-peripheral bridge: captures a CPU I/O access, runs the req/ack
// handshake with a timeout, and buffers the returned read data.
module io_port_fsm
    import cpu_bus_pkg::*;
#(
    parameter int IO_AW   = IO_AW_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             sel_i,
    input  logic             we_i,
    input  logic [IO_AW-1:0] addr_i,
    input  logic [7:0]       wdata_i,
    input  logic             io_ack_i,
    input  logic [7:0]       io_rdata_i,
    output io_state_e        state_o,
    output logic             io_req_o,
    output logic             io_we_o,
    output logic [IO_AW-1:0] io_addr_o,
    output logic [7:0]       io_wdata_o,
    output logic [7:0]       rbuf_o,
    output logic             err_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    io_state_e        state_q;
    logic             io_req_q;
    logic             io_we_q;
    logic [IO_AW-1:0] io_addr_q;
    logic [7:0]       io_wdata_q;
    logic [7:0]       rbuf_q;
    logic             err_q;
    logic [CNT_W-1:0] cnt_q;

    // Handshake FSM; io_ack is only honoured while a request is outstanding.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            io_req_q   <= 1'b0;
            io_we_q    <= 1'b0;
            io_addr_q  <= '0;
            io_wdata_q <= 8'h00;
            rbuf_q     <= OPEN_BUS;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (sel_i) begin
                        io_addr_q  <= addr_i;
                        io_we_q    <= we_i;
                        io_wdata_q <= wdata_i;
                        io_req_q   <= 1'b1;
                        cnt_q      <= '0;
                        state_q    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (io_ack_i) begin
                        io_req_q <= 1'b0;
                        rbuf_q   <= io_rdata_i;
                        state_q  <= ST_DONE;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        // Dead peripheral: finish the access with open-bus data.
                        io_req_q <= 1'b0;
                        rbuf_q   <= OPEN_BUS;
                        err_q    <= 1'b1;
                        state_q  <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q  <= ST_IDLE;
                    io_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign state_o    = state_q;
    assign io_req_o   = io_req_q;
    assign io_we_o    = io_we_q;
    assign io_addr_o  = io_addr_q;
    assign io_wdata_o = io_wdata_q;
    assign rbuf_o     = rbuf_q;
    assign err_o      = err_q;

endmodule

// File: rtl/bus_responder.sv
// 65C02 bus responder: decodes the CPU address, serves a mirrored internal
// RAM with no wait states and stalls the CPU through RDY for I/O accesses.
module bus_responder
    import cpu_bus_pkg::*;
#(
    parameter int          RAM_AW  = 15,
    parameter logic [15:0] IO_BASE = IO_BASE_DEF,
    parameter int          IO_AW   = IO_AW_DEF,
    parameter int          TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             RST,
    input  logic [15:0]      AD,
    input  logic [7:0]       DO,
    input  logic             WE,
    output logic [7:0]       DI,
    output logic             RDY,
    output logic             io_req,
    output logic             io_we,
    output logic [IO_AW-1:0] io_addr,
    output logic [7:0]       io_wdata,
    input  logic [7:0]       io_rdata,
    input  logic             io_ack,
    output logic             err
);

    logic              io_sel_s;
    logic              ram_sel_s;
    logic              io_done_s;
    logic [RAM_AW-1:0] ram_idx_s;
    io_state_e         state_s;
    logic [7:0]        rbuf_s;
    logic [7:0]        di_q;
    logic [7:0]        ram_q [2**RAM_AW];

    assign io_sel_s  = in_io_window(AD, IO_BASE, IO_AW);
    assign ram_sel_s = ~io_sel_s;
    assign io_done_s = io_sel_s & (state_s == ST_DONE);
    assign RDY       = ~(io_sel_s & (state_s != ST_DONE));
    assign ram_idx_s = AD[RAM_AW-1:0];

    io_port_fsm #(
        .IO_AW   (IO_AW),
        .TIMEOUT (TIMEOUT)
    ) u_io_port_fsm (
        .clk_i      (clk),
        .rst_i      (RST),
        .sel_i      (io_sel_s),
        .we_i       (WE),
        .addr_i     (AD[IO_AW-1:0]),
        .wdata_i    (DO),
        .io_ack_i   (io_ack),
        .io_rdata_i (io_rdata),
        .state_o    (state_s),
        .io_req_o   (io_req),
        .io_we_o    (io_we),
        .io_addr_o  (io_addr),
        .io_wdata_o (io_wdata),
        .rbuf_o     (rbuf_s),
        .err_o      (err)
    );

    // RAM write port; contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (!RST && ram_sel_s && RDY && WE) begin
            ram_q[ram_idx_s] <= DO;
        end
    end

    // Read data register: RAM reads see the old contents on a write cycle.
    always_ff @(posedge clk) begin
        if (RST) begin
            di_q <= OPEN_BUS;
        end else if (ram_sel_s && RDY) begin
            di_q <= ram_q[ram_idx_s];
        end else if (io_done_s && !io_we) begin
            di_q <= rbuf_s;
        end
    end

    assign DI = di_q;

endmodule

// File: tb/tb_bus_responder.sv
// Directed bench for bus_responder: a default instance for RAM/I/O traffic
// and a short-timeout instance for the dead-peripheral path.
module tb_bus_responder;

    logic        clk = 1'b0;
    logic        RST;
    logic [15:0] AD;
    logic [7:0]  DO;
    logic        WE;
    logic [7:0]  DI;
    logic        RDY;
    logic        io_req, io_we;
    logic [7:0]  io_addr, io_wdata, io_rdata;
    logic        io_ack, err;

    logic [15:0] ad2;
    logic [7:0]  do2;
    logic        we2;
    logic [7:0]  di2;
    logic        rdy2, io_req2, io_we2, err2;
    logic [7:0]  io_addr2, io_wdata2, io_rdata2;
    logic        io_ack2;

    int checks   = 0;
    int failures = 0;
    int stalls, reqs;

    always #5 clk = ~clk;

    bus_responder u_dut (
        .clk(clk), .RST(RST), .AD(AD), .DO(DO), .WE(WE), .DI(DI), .RDY(RDY),
        .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_rdata(io_rdata), .io_ack(io_ack), .err(err)
    );

    bus_responder #(.TIMEOUT(4)) u_to (
        .clk(clk), .RST(RST), .AD(ad2), .DO(do2), .WE(we2), .DI(di2), .RDY(rdy2),
        .io_req(io_req2), .io_we(io_we2), .io_addr(io_addr2), .io_wdata(io_wdata2),
        .io_rdata(io_rdata2), .io_ack(io_ack2), .err(err2)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One CPU I/O access; the peripheral acks in REQ cycle ack_at (0 = never).
    task automatic io_cycle(input logic [15:0] a, input logic [7:0] d, input logic w,
                            input int ack_at, input logic [7:0] rd,
                            output int n_stall, output int n_req);
        logic done;
        AD = a; DO = d; WE = w;
        n_stall = 0; n_req = 0; done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            if (io_req) begin
                n_req++;
                chk("io_addr_held", {8'h00, io_addr}, {8'h00, a[7:0]});
                chk("io_we_held", {15'h0, io_we}, {15'h0, w});
                if (w) chk("io_wdata_held", {8'h00, io_wdata}, {8'h00, d});
                io_ack   = (n_req == ack_at);
                io_rdata = (n_req == ack_at) ? rd : 8'h00;
            end else begin
                io_ack = 1'b0;
            end
            if (RDY) done = 1'b1;
            else n_stall++;
        end
        chk("io_access_completes", {15'h0, done}, 16'h0001);
        step();
        io_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic done2;
        RST = 1'b1; AD = 16'h0000; DO = 8'h00; WE = 1'b0;
        io_ack = 1'b0; io_rdata = 8'h00;
        ad2 = 16'h0000; do2 = 8'h00; we2 = 1'b0; io_ack2 = 1'b0; io_rdata2 = 8'h00;
        step(); step();
        RST = 1'b0;
        @(negedge clk);
        chk("rst_DI", {8'h00, DI}, 16'h00FF);
        chk("rst_io_req", {15'h0, io_req}, 16'h0000);
        chk("rst_err", {15'h0, err}, 16'h0000);
        chk("rst_RDY_ram", {15'h0, RDY}, 16'h0001);
        step();

        // RAM write, read back and mirror read.
        AD = 16'h0200; DO = 8'hA5; WE = 1'b1;
        @(negedge clk); chk("ram_wr_RDY", {15'h0, RDY}, 16'h0001);
        step();
        AD = 16'h0300; DO = 8'h5A; WE = 1'b1;
        step();
        AD = 16'h0200; WE = 1'b0;
        @(negedge clk); chk("ram_rd_RDY", {15'h0, RDY}, 16'h0001);
        step();
        chk("ram_rd_DI", {8'h00, DI}, 16'h00A5);
        AD = 16'h8200;
        step();
        chk("ram_mirror_DI", {8'h00, DI}, 16'h00A5);

        // I/O read, ack in the first REQ cycle.
        io_cycle(16'hFE10, 8'h00, 1'b0, 1, 8'h3C, stalls, reqs);
        chk("io_rd_stalls", 16'(stalls), 16'd2);
        chk("io_rd_reqs", 16'(reqs), 16'd1);
        chk("io_rd_DI", {8'h00, DI}, 16'h003C);
        chk("io_rd_err", {15'h0, err}, 16'h0000);

        // I/O write, ack in the sixth REQ cycle.
        io_cycle(16'hFE01, 8'h77, 1'b1, 6, 8'hEE, stalls, reqs);
        chk("io_wr_stalls", 16'(stalls), 16'd7);
        chk("io_wr_reqs", 16'(reqs), 16'd6);
        chk("io_wr_DI_kept", {8'h00, DI}, 16'h003C);

        // Back-to-back I/O reads, then a RAM read with no gap.
        io_cycle(16'hFE00, 8'h00, 1'b0, 1, 8'h11, stalls, reqs);
        chk("b2b0_reqs", 16'(reqs), 16'd1);
        chk("b2b0_DI", {8'h00, DI}, 16'h0011);
        io_cycle(16'hFE01, 8'h00, 1'b0, 2, 8'h22, stalls, reqs);
        chk("b2b1_reqs", 16'(reqs), 16'd2);
        chk("b2b1_stalls", 16'(stalls), 16'd3);
        chk("b2b1_DI", {8'h00, DI}, 16'h0022);
        AD = 16'h0300; WE = 1'b0;
        @(negedge clk); chk("b2b_ram_RDY", {15'h0, RDY}, 16'h0001);
        step();
        chk("b2b_ram_DI", {8'h00, DI}, 16'h005A);
        chk("no_err_main", {15'h0, err}, 16'h0000);

        // Timeout on the TIMEOUT=4 instance.
        ad2 = 16'h0100; do2 = 8'h12; we2 = 1'b1;
        step();
        we2 = 1'b0;
        step();
        chk("to_pre_DI", {8'h00, di2}, 16'h0012);
        ad2 = 16'hFE05;
        stalls = 0; reqs = 0; done2 = 1'b0;
        for (int c = 0; c < 50 && !done2; c++) begin
            @(negedge clk);
            if (io_req2) reqs++;
            if (rdy2) done2 = 1'b1;
            else stalls++;
        end
        chk("to_completes", {15'h0, done2}, 16'h0001);
        chk("to_req_cycles", 16'(reqs), 16'd4);
        chk("to_stalls", 16'(stalls), 16'd5);
        step();
        chk("to_DI", {8'h00, di2}, 16'h00FF);
        chk("to_err", {15'h0, err2}, 16'h0001);
        ad2 = 16'h0100;
        step();
        chk("to_err_sticky", {15'h0, err2}, 16'h0001);
        chk("to_ram_after_DI", {8'h00, di2}, 16'h0012);

        // Reset while a request is outstanding, with a coincident and a late ack.
        AD = 16'hFE20; WE = 1'b0;
        done2 = 1'b0;
        for (int c = 0; c < 10 && !done2; c++) begin
            @(negedge clk);
            if (io_req) done2 = 1'b1;
        end
        chk("rstreq_seen", {15'h0, done2}, 16'h0001);
        RST = 1'b1; io_ack = 1'b1; io_rdata = 8'h99;
        step();
        chk("rstreq_io_req", {15'h0, io_req}, 16'h0000);
        chk("rstreq_DI", {8'h00, DI}, 16'h00FF);
        chk("rstreq_err2_clr", {15'h0, err2}, 16'h0000);
        RST = 1'b0; AD = 16'h0200;
        @(negedge clk);
        chk("late_ack_RDY", {15'h0, RDY}, 16'h0001);
        chk("late_ack_io_req", {15'h0, io_req}, 16'h0000);
        step();
        io_ack = 1'b0;
        chk("late_ack_DI", {8'h00, DI}, 16'h00A5);
        io_cycle(16'hFE30, 8'h00, 1'b0, 1, 8'h44, stalls, reqs);
        chk("post_rst_stalls", 16'(stalls), 16'd2);
        chk("post_rst_DI", {8'h00, DI}, 16'h0044);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
